// File: rtl/weight_arb_pkg.sv
// ---------------------------------------------------------------------------
// weight_arb_pkg
// Shared types and helpers for the weight memory fetch arbiter.
//   - state_e      : burst FSM encoding (IDLE / BURST / DONE)
//   - DEF_*        : default width parameters
//   - unpack_slice : extracts field i of a packed per-requester bus
// ---------------------------------------------------------------------------
package weight_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_LEN_WIDTH  = 8;

    // Widest single field and widest packed bus (8 requesters) the helper handles.
    localparam int MAX_FIELD_W = 32;
    localparam int MAX_BUS_W   = 8 * MAX_FIELD_W;

    // Returns bits [idx*w +: w] of bus, zero-extended to MAX_FIELD_W.
    function automatic logic [MAX_FIELD_W-1:0] unpack_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_FIELD_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = '0;
        for (int b = 0; b < MAX_FIELD_W; b++) begin
            if (b < w) begin
                mask[b] = 1'b1;
            end
        end
        return shifted[MAX_FIELD_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/weight_fetch_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational arbiter. Searches req_i starting at ptr_i, wrapping, and
// grants the first asserted request.
// With WEIGHT_ARB_FIXED_PRIO_EN defined the pointer is ignored and the
// lowest index always wins.
// Ports:
//   req_i   in  NUM_REQ   request vector
//   ptr_i   in  ID_WIDTH  search start index
//   grant_o out NUM_REQ   one-hot grant, zero when no request
//   idx_o   out ID_WIDTH  index of the winner
//   any_o   out 1         at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import weight_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                any_o
);

`ifdef WEIGHT_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WEIGHT_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
`endif
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/weight_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// weight_fetch_arbiter
// Shares the single combinational read port of the weight memory between
// NUM_REQ engines fetching bursts of consecutive words. One burst at a time;
// beats are streamed back with valid/ready, requester id and last flag.
// Option macro: WEIGHT_ARB_FIXED_PRIO_EN (fixed lowest-index priority, no
// round-robin pointer). Default build is round-robin.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot grant)
//   req_base, req_len   packed per-requester base address / word count
//   mem_addr, mem_data  weight memory read port (same-cycle data)
//   rsp_valid/rsp_ready response handshake
//   rsp_data, rsp_id, rsp_last  beat payload
//   busy                state other than IDLE
//   done                one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module weight_fetch_arbiter
    import weight_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          rsp_last,
    output logic                          busy,
    output logic                          done
);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   win;
    logic                  any_req;
    logic [ID_WIDTH-1:0]   arb_ptr;

    logic [MAX_BUS_W-1:0]   base_bus, len_bus;
    logic [MAX_FIELD_W-1:0] win_base, win_len;
    logic [LEN_WIDTH-1:0]   win_len_w;
    logic                   unused_hi;

    assign base_bus  = MAX_BUS_W'(req_base);
    assign len_bus   = MAX_BUS_W'(req_len);
    assign win_base  = unpack_slice(base_bus, int'(win), ADDR_WIDTH);
    assign win_len   = unpack_slice(len_bus, int'(win), LEN_WIDTH);
    assign win_len_w = win_len[LEN_WIDTH-1:0];
    assign unused_hi = ^{win_base[MAX_FIELD_W-1:ADDR_WIDTH], win_len[MAX_FIELD_W-1:LEN_WIDTH]};

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (arb_ptr),
        .grant_o (grant),
        .idx_o   (win),
        .any_o   (any_req)
    );

`ifdef WEIGHT_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && any_req) begin
            if (int'(win) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign arb_ptr = ptr_q;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d    = win;
                    addr_d  = win_base[ADDR_WIDTH-1:0];
                    rem_d   = win_len_w;
                    state_d = (win_len_w != '0) ? BURST : DONE;
                end
            end
            BURST: begin
                if (rsp_ready) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // Grant is only visible in IDLE so a request can never be accepted mid-burst.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign mem_addr  = addr_q;
    assign rsp_valid = (state_q == BURST);
    assign rsp_data  = mem_data;
    assign rsp_id    = id_q;
    assign rsp_last  = (state_q == BURST) && (rem_q == LEN_WIDTH'(1));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
module tb_weight_fetch_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NR = 2;
    localparam int LW = 8;
    localparam int IW = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_base;
    logic [NR*LW-1:0] req_len;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             rsp_last;
    logic             busy;
    logic             done;

    weight_fetch_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_base  (req_base),
        .req_len   (req_len),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Weight store model: mem[a] = a.
    assign mem_data = DW'(mem_addr);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
        logic [AW-1:0] addr;
    } beat_t;

    typedef struct packed {
        logic [1:0]    vld;
        logic [AW-1:0] base0;
        logic [LW-1:0] len0;
        logic [AW-1:0] base1;
        logic [LW-1:0] len1;
        logic [IW-1:0] first;
    } vec_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_cmp    = 0;
    int    n_err    = 0;
    int    done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic [IW-1:0] id, input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        for (int k = 0; k < len; k++) begin
            a = base + AW'(k);
            exp_q.push_back('{data: DW'(a), id: id, last: (k == len - 1), addr: a});
        end
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] base, input logic [LW-1:0] len);
        req_base[idx*AW +: AW] = base;
        req_len[idx*LW +: LW]  = len;
    endtask

    // Scoreboard: every handshaken beat is popped and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_unexpected: got data 0x%0h expected no beat", rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", rsp_data, mon_e.data);
                    chk("beat_id",   rsp_id,   mon_e.id);
                    chk("beat_last", rsp_last, mon_e.last);
                    chk("beat_addr", mem_addr, mon_e.addr);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input int n, input vec_t v);
        int         exp_done;
        int         start_done;
        int         n_acc;
        int         budget;
        logic [1:0] acc;
        logic [1:0] first_m;
        logic [1:0] exp_m;
        first_m  = 2'b01 << v.first;
        exp_done = int'(v.vld[0]) + int'(v.vld[1]);
        set_req(0, v.base0, v.len0);
        set_req(1, v.base1, v.len1);
        if (v.first == 1'b0) begin
            if (v.vld[0]) push_burst(1'b0, v.base0, int'(v.len0));
            if (v.vld[1]) push_burst(1'b1, v.base1, int'(v.len1));
        end else begin
            if (v.vld[1]) push_burst(1'b1, v.base1, int'(v.len1));
            if (v.vld[0]) push_burst(1'b0, v.base0, int'(v.len0));
        end
        start_done = done_cnt;
        n_acc      = 0;
        req_valid  = v.vld;
        for (budget = 0; budget < 100 && (done_cnt - start_done < exp_done || req_valid != 2'b00); budget++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != 2'b00) begin
                exp_m = (n_acc == 0) ? first_m : (v.vld & ~first_m);
                chk($sformatf("vec%0d_grant%0d", n, n_acc), acc, exp_m);
                n_acc++;
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        chk($sformatf("vec%0d_timeout", n), budget < 100, 1'b1);
        chk($sformatf("vec%0d_done_count", n), done_cnt - start_done, exp_done);
        chk($sformatf("vec%0d_beats_left", n), exp_q.size(), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int            d0;
        int            hs;
        int            b;
        logic          pat[5];
        logic [AW-1:0] pa[5];

        vecs[0] = '{vld: 2'b11, base0: 10'h100, len0: 8'd2, base1: 10'h200, len1: 8'd2, first: 1'b0};
        vecs[1] = '{vld: 2'b11, base0: 10'h140, len0: 8'd3, base1: 10'h240, len1: 8'd1, first: 1'b0};
        vecs[2] = '{vld: 2'b10, base0: 10'h000, len0: 8'd0, base1: 10'h3FE, len1: 8'd4, first: 1'b1};
        vecs[3] = '{vld: 2'b01, base0: 10'h000, len0: 8'd0, base1: 10'h000, len1: 8'd0, first: 1'b0};
        vecs[4] = '{vld: 2'b11, base0: 10'h0AA, len0: 8'd1, base1: 10'h155, len1: 8'd0, first: 1'b1};
        vecs[5] = '{vld: 2'b01, base0: 10'h2F0, len0: 8'd5, base1: 10'h000, len1: 8'd0, first: 1'b0};
        vecs[6] = '{vld: 2'b11, base0: 10'h060, len0: 8'd0, base1: 10'h070, len1: 8'd0, first: 1'b1};

        // Reset, with requests present: grant must stay low.
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_base  = {10'h222, 10'h111};
        req_len   = {8'd3, 8'd3};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_last",  rsp_last,  1'b0);
        chk("rst_rsp_id",    rsp_id,    1'b0);
        chk("rst_mem_addr",  mem_addr,  10'h000);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_done",      done,      1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Single burst timing: beats in N+1..N+4, last on the 4th, done one cycle later.
        set_req(0, 10'h010, 8'd4);
        push_burst(1'b0, 10'h010, 4);
        req_valid = 2'b01;
        @(negedge clk);
        chk("sb_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("sb_valid%0d", k), rsp_valid, 1'b1);
            chk($sformatf("sb_last%0d", k),  rsp_last,  k == 3);
            chk($sformatf("sb_done%0d", k),  done,      1'b0);
        end
        @(negedge clk);
        chk("sb_done_pulse", done,      1'b1);
        chk("sb_done_valid", rsp_valid, 1'b0);
        chk("sb_done_busy",  busy,      1'b1);
        @(negedge clk);
        chk("sb_after_done", done, 1'b0);
        chk("sb_after_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // Zero length: done the cycle after accept, busy for that cycle only.
        set_req(0, 10'h044, 8'd0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("z_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("z_done",  done,      1'b1);
        chk("z_busy",  busy,      1'b1);
        chk("z_valid", rsp_valid, 1'b0);
        @(negedge clk);
        chk("z_done_end", done, 1'b0);
        chk("z_busy_end", busy, 1'b0);
        @(posedge clk);
        #1;

        // Backpressure: ready 1,0,0,1,1 over a 3-word burst.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pa  = '{10'h120, 10'h121, 10'h121, 10'h121, 10'h122};
        set_req(1, 10'h120, 8'd3);
        push_burst(1'b1, 10'h120, 3);
        req_valid = 2'b10;
        @(negedge clk);
        chk("bp_grant", req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            rsp_ready = pat[c];
            @(negedge clk);
            chk($sformatf("bp_valid%0d", c), rsp_valid, 1'b1);
            chk($sformatf("bp_addr%0d", c),  mem_addr,  pa[c]);
            chk($sformatf("bp_data%0d", c),  rsp_data,  DW'(pa[c]));
            chk($sformatf("bp_last%0d", c),  rsp_last,  c == 4);
            if (rsp_valid && rsp_ready) hs++;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        chk("bp_handshakes", hs, 3);
        @(negedge clk);
        chk("bp_done", done, 1'b1);
        chk("bp_beats_left", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset during beat 2 of an 8-word burst, then re-posted request.
        set_req(1, 10'h030, 8'd8);
        push_burst(1'b1, 10'h030, 8);
        req_valid = 2'b10;
        @(negedge clk);
        chk("mr_grant", req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 2'b10;
        d0        = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        push_burst(1'b1, 10'h030, 8);
        @(negedge clk);
        chk("mr_rsp_valid", rsp_valid, 1'b0);
        chk("mr_rsp_last",  rsp_last,  1'b0);
        chk("mr_rsp_id",    rsp_id,    1'b0);
        chk("mr_mem_addr",  mem_addr,  10'h000);
        chk("mr_busy",      busy,      1'b0);
        chk("mr_done",      done,      1'b0);
        chk("mr_regrant",   req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        for (b = 0; b < 50 && done_cnt == d0; b++) begin
            @(posedge clk);
            #1;
        end
        chk("mr_done_count", done_cnt - d0, 1);
        chk("mr_beats_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_fetch_arbiter.md
# weight_fetch_arbiter

Shares the single read port of the CNN weight memory between `NUM_REQ` compute engines (conv, FC, …) that fetch bursts of consecutive weight words. Each requester posts a base address and a word count. The block grants one requester at a time, drives the weight memory address, and streams the returned words back with a valid/ready handshake, a requester ID and a last-beat flag. It sits between the engines and the combinational-read weight store, which returns data in the same cycle as the address.

## Interface
- `DATA_WIDTH`, 32, weight word width; must match the weight memory.
- `ADDR_WIDTH`, 10, weight memory address width.
- `NUM_REQ`, 2, number of requesters, 2..8.
- `LEN_WIDTH`, 8, burst length field width, in words.
- `ID_WIDTH`, `$clog2(NUM_REQ)`, requester index width (derived).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester burst request.
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted on `req_valid[i] && req_ready[i]`.
- `req_base`  in  NUM_REQ*ADDR_WIDTH  packed start addresses; slice i belongs to requester i.
- `req_len`  in  NUM_REQ*LEN_WIDTH  packed word counts; 0 is legal.
- `mem_addr`  out  ADDR_WIDTH  address to the weight memory.
- `mem_data`  in  DATA_WIDTH  combinational read data from the weight memory.
- `rsp_valid`  out  1  response beat valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  DATA_WIDTH  beat data; equals `mem_data`.
- `rsp_id`  out  ID_WIDTH  index of the granted requester.
- `rsp_last`  out  1  final beat of the burst.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- FSM states: IDLE, BURST, DONE. State encoding is fixed in the package.
- **IDLE:**
  - Arbitration is combinational over `req_valid`.
  - Round-robin: search starts at pointer `rr_ptr` and wraps; the first valid requester wins.
  - `req_ready` is one-hot on the winner and all-zero when there are no requests.
- **Accept:**
  - Latch `rsp_id`, set `mem_addr = base`, set `remaining = len`, set `rr_ptr = (winner+1) mod NUM_REQ`.
  - Next state is BURST if `len != 0`, otherwise DONE.
- **BURST:**
  - `rsp_valid` = 1 and `rsp_data` = `mem_data`.
  - `rsp_last` = 1 when `remaining == 1`.
  - On `rsp_valid && rsp_ready`: `mem_addr` += 1, wrapping modulo 2^ADDR_WIDTH; `remaining` -= 1.
  - On the last-beat handshake, go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE. `req_ready` is 0 in this state.
- **Requester rules:** `req_valid`, `req_base` and `req_len` must stay stable until accepted. Dropping `req_valid` early is a protocol violation and the resulting behaviour is undefined.
- **Backpressure:** while `rsp_ready` = 0, `mem_addr`, `rsp_data`, `rsp_id` and `rsp_last` hold stable.
- **Simultaneous requests:** exactly one is granted. Losers keep their requests pending and are served in round-robin order.
- **Reset mid-burst:** the burst is aborted with no `rsp_last` and no `done`. Pending requests must be re-posted, or simply held, after reset.

## Timing
- **Reset values:**
  - Outputs: `rsp_valid` 0, `rsp_last` 0, `rsp_id` 0, `mem_addr` 0, `busy` 0, `done` 0.
  - `req_ready` is forced to 0 while `rst` is high.
  - Internal: `rr_ptr` 0, state IDLE.
- **Request-to-data latency:** accept in cycle N; first beat is valid in N+1 with `rsp_data = mem[base]`.
- **Throughput:** one beat per cycle while `rsp_ready` is held high. A burst of length L with no stalls occupies cycles N+1 … N+L; `done` is asserted in N+L+1.
- **Len 0:** `done` in N+1 and no beats.
- **Gap between bursts:** the next grant happens no earlier than the cycle after DONE, which is a 2-cycle gap between the last beat and the next first beat.
- `busy` is registered: 1 from N+1 until the cycle DONE is exited.

## Configuration
- `WEIGHT_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority; the lowest requester index always wins and `rr_ptr` is not implemented.
  - **Undefined (default):** round-robin as described under Operation.

## Structure
- Package `weight_arb_pkg` holds:
  - the FSM state enum (`IDLE`, `BURST`, `DONE`);
  - the default width localparams;
  - a function that unpacks slice i of a packed request bus.
- Sub-module `rr_arbiter`: combinational request vector plus pointer in, one-hot grant plus winner index out. It contains the `WEIGHT_ARB_FIXED_PRIO_EN` switch.
- The top level holds the FSM, address and remaining counters, and the response path.

## Test plan
- **Single burst:** req0 with base=0x010, len=4, `rsp_ready` held 1; memory preloaded so that mem[a] = a.
  - Beats 0x10..0x13 appear in consecutive cycles with `rsp_id` = 0.
  - `rsp_last` is high on 0x13 only; `done` pulses one cycle later.
- **Contention:** req0 and req1 both raised in the same cycle after reset, each len=2.
  - req0 is served first, then req1, and `rr_ptr` advances.
  - Another simultaneous pair then grants req0 again, because the pointer has wrapped.
- **Backpressure:** len=3 with `rsp_ready` toggled 1,0,0,1,1.
  - `rsp_data` and `mem_addr` are stable during the stalls.
  - Exactly 3 handshakes occur, with no duplicated or dropped words.
- **Address wrap:** base=0x3FE, len=4.
  - Addresses are 0x3FE, 0x3FF, 0x000, 0x001.
- **Zero length:** len=0.
  - No `rsp_valid`; `done` in the cycle after accept; `busy` high for that one cycle.
- **Reset mid-burst:** assert `rst` during beat 2 of a len=8 burst.
  - The next cycle shows all outputs at their reset values.
  - No `done`; the re-posted request is then served normally.
